dcache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's MEM stage and the off-chip block memory. The MEM stage issues word loads and stores. The block answers hits in the same cycle. On a miss it holds `cpu_stall_o` high while a finite-state machine writes back the dirty victim line and fills the new line over a 256-bit request/ack memory port.

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/dcache_if.sv | 32 +++
 rtl/dcache_sram.sv | 58 +++++
 rtl/dcache_controller.sv | 118 +++++++++++
 tb/tb_dcache_controller.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Field widths come from the line count and the address width.
package dcache_pkg;

    localparam int BLOCK_W    = 256;
    localparam int OFFSET_W   = 5;
    localparam int WORD_SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic int idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int tag_w(input int addr_w, input int num_lines);
        return addr_w - OFFSET_W - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signal bundle of the data cache.
// The cache uses the slave view; the environment (CPU plus memory) uses the master view.
interface dcache_if #(
    parameter int ADDR_W = 32
);
    import dcache_pkg::*;

    logic               cpu_req_i;
    logic               cpu_we_i;
    logic [ADDR_W-1:0]  cpu_addr_i;
    logic [31:0]        cpu_wdata_i;
    logic [31:0]        cpu_rdata_o;
    logic               cpu_stall_o;

    logic               mem_req_o;
    logic               mem_we_o;
    logic [ADDR_W-1:0]  mem_addr_o;
    logic [BLOCK_W-1:0] mem_wdata_o;
    logic [BLOCK_W-1:0] mem_rdata_i;
    logic               mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
        input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

endinterface

// File: rtl/dcache_sram.sv
// Valid/dirty/tag/data storage: asynchronous read, one synchronous write port
// that either merges a single word (store hit) or replaces the whole line (fill).
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 23
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [IDX_W-1:0]      idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [BLOCK_W-1:0]    rd_data,
    input  logic                  word_we,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [31:0]           word_data,
    input  logic                  fill_we,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [BLOCK_W-1:0]    fill_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays have no reset; clearing valid is enough and keeps them plain RAM.
    always_ff @(posedge clk_i) begin
        if (fill_we) begin
            tag_q[idx]  <= fill_tag;
            data_q[idx] <= fill_data;
        end else if (word_we) begin
            data_q[idx][{word_sel, 5'b0} +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache: same-cycle hits, and a
// WRITEBACK/ALLOCATE miss FSM driving a 256-bit request/ack memory port.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int ADDR_W    = 32
) (
    input  logic    clk_i,
    input  logic    rst_i,
    dcache_if.slave bus
);

    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(ADDR_W, NUM_LINES);

    state_t               state;
    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [WORD_SEL_W-1:0] word_sel;
    logic                 line_valid;
    logic                 line_dirty;
    logic [TAG_W-1:0]     line_tag;
    logic [BLOCK_W-1:0]   line_data;
    logic                 hit;
    logic                 idle_hit;
    logic                 unused_addr_lsb;

    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [BLOCK_W-1:0]   mem_wdata_q;

    assign req_idx         = bus.cpu_addr_i[IDX_W+OFFSET_W-1:OFFSET_W];
    assign req_tag         = bus.cpu_addr_i[ADDR_W-1:IDX_W+OFFSET_W];
    assign word_sel        = bus.cpu_addr_i[OFFSET_W-1:2];
    assign unused_addr_lsb = ^bus.cpu_addr_i[1:0];

    assign hit      = line_valid && (line_tag == req_tag);
    assign idle_hit = (state == IDLE) && hit;

    assign bus.cpu_stall_o = bus.cpu_req_i && !idle_hit;
    assign bus.cpu_rdata_o = (bus.cpu_req_i && idle_hit && !bus.cpu_we_i)
                           ? line_data[{word_sel, 5'b0} +: 32] : 32'h0;

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;

    // A reset in the same cycle as an ack or a store must not leave a half-written line behind.
    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_sram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .idx       (req_idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .word_we   (bus.cpu_req_i && bus.cpu_we_i && idle_hit && !rst_i),
        .word_sel  (word_sel),
        .word_data (bus.cpu_wdata_i),
        .fill_we   ((state == ALLOCATE) && bus.mem_ack_i && !rst_i),
        .fill_tag  (req_tag),
        .fill_data (bus.mem_rdata_i)
    );

    // Memory-port outputs are registered on state entry so they hold steady until the ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req_i && !hit) begin
                        mem_req_q <= 1'b1;
                        if (line_valid && line_dirty) begin
                            state       <= WRITEBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {line_tag, req_idx, {OFFSET_W{1'b0}}};
                            mem_wdata_q <= line_data;
                        end else begin
                            state      <= ALLOCATE;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        state      <= ALLOCATE;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {req_tag, req_idx, {OFFSET_W{1'b0}}};
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized bench for dcache_controller: a line-level cache model plus a
// block-memory model predict every stall, load value and memory transaction.
module tb_dcache_controller;

    localparam int NL = 16;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    dcache_if #(.ADDR_W(32)) bus ();

    dcache_controller #(.NUM_LINES(NL), .ADDR_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: what each cache line should hold, and what memory holds.
    bit           m_valid [NL];
    bit           m_dirty [NL];
    int unsigned  m_tag   [NL];
    logic [255:0] m_data  [NL];
    logic [255:0] mem     [logic [31:0]];

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [255:0] mem_block(input logic [31:0] baddr);
        logic [255:0] blk;
        if (!mem.exists(baddr)) begin
            for (int k = 0; k < 8; k++) blk[k*32 +: 32] = (baddr + 32'(k * 4)) ^ 32'hA5A5_0000;
            mem[baddr] = blk;
        end
        return mem[baddr];
    endfunction

    function automatic logic [255:0] junk();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        bus.cpu_req_i = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle_cycle(input bit ack);
        bus.cpu_req_i   = 1'b0;
        bus.mem_ack_i   = ack;
        bus.mem_rdata_i = junk();
        @(negedge clk);
        check("idle_stall", bus.cpu_stall_o, 1'b0);
        check("idle_rdata", bus.cpu_rdata_o, 32'h0);
        check("idle_mem_req", bus.mem_req_o, 1'b0);
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
    endtask

    // One CPU access: predicted miss sequence (if any) followed by the hit cycle.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          input int lat_wb, input int lat_al);
        int unsigned  idx   = (addr / 32) % NL;
        int unsigned  tag   = addr / (32 * NL);
        int unsigned  w     = (addr / 4) % 8;
        logic [31:0]  baddr = tag * 32 * NL + idx * 32;
        logic [31:0]  vaddr;
        bus.cpu_req_i   = 1'b1;
        bus.cpu_we_i    = we;
        bus.cpu_addr_i  = addr;
        bus.cpu_wdata_i = wd;
        if (!(m_valid[idx] && m_tag[idx] == tag)) begin
            @(negedge clk);
            check("miss_stall_c0", bus.cpu_stall_o, 1'b1);
            check("miss_req_c0", bus.mem_req_o, 1'b0);
            @(posedge clk); #1;
            if (m_dirty[idx]) begin
                vaddr = m_tag[idx] * 32 * NL + idx * 32;
                for (int c = 1; c <= lat_wb; c++) begin
                    bus.mem_rdata_i = junk();
                    @(negedge clk);
                    check("wb_stall", bus.cpu_stall_o, 1'b1);
                    check("wb_req", bus.mem_req_o, 1'b1);
                    check("wb_we", bus.mem_we_o, 1'b1);
                    check("wb_addr", bus.mem_addr_o, vaddr);
                    check("wb_wdata", bus.mem_wdata_o, m_data[idx]);
                    if (c == lat_wb) bus.mem_ack_i = 1'b1;
                    @(posedge clk); #1;
                    bus.mem_ack_i = 1'b0;
                end
                mem[vaddr] = m_data[idx];
            end
            for (int c = 1; c <= lat_al; c++) begin
                bus.mem_rdata_i = junk();
                @(negedge clk);
                check("al_stall", bus.cpu_stall_o, 1'b1);
                check("al_req", bus.mem_req_o, 1'b1);
                check("al_we", bus.mem_we_o, 1'b0);
                check("al_addr", bus.mem_addr_o, baddr);
                if (c == lat_al) begin
                    bus.mem_ack_i   = 1'b1;
                    bus.mem_rdata_i = mem_block(baddr);
                end
                @(posedge clk); #1;
                bus.mem_ack_i   = 1'b0;
                bus.mem_rdata_i = junk();
            end
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
            m_data[idx]  = mem_block(baddr);
        end
        @(negedge clk);
        check("hit_stall", bus.cpu_stall_o, 1'b0);
        check("hit_mem_req", bus.mem_req_o, 1'b0);
        check("hit_rdata", bus.cpu_rdata_o, we ? 32'h0 : m_data[idx][w*32 +: 32]);
        if (we) begin
            m_data[idx][w*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [255:0] blk;
        logic [31:0]  addr;
        rst             = 1'b1;
        bus.cpu_req_i   = 1'b0;
        bus.cpu_we_i    = 1'b0;
        bus.cpu_addr_i  = '0;
        bus.cpu_wdata_i = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_mem_req", bus.mem_req_o, 1'b0);
        check("rst_mem_we", bus.mem_we_o, 1'b0);
        check("rst_mem_addr", bus.mem_addr_o, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata_o, 256'h0);
        check("rst_stall", bus.cpu_stall_o, 1'b0);
        check("rst_rdata", bus.cpu_rdata_o, 32'h0);
        @(posedge clk); #1;

        // Cold load miss, ack in cycle 10, word0 = DEADBEEF.
        blk = mem_block(32'h100);
        blk[31:0] = 32'hDEAD_BEEF;
        mem[32'h100] = blk;
        access(1'b0, 32'h100, 32'h0, 1, 10);

        // Store hit then load hit.
        access(1'b1, 32'h104, 32'h1234_5678, 1, 1);
        access(1'b0, 32'h104, 32'h0, 1, 1);

        // Dirty conflict on index 8: write back 0x100, fill 0x300.
        access(1'b0, 32'h300, 32'h0, 3, 2);
        check("wb_word1_in_mem", mem[32'h100][63:32], 32'h1234_5678);

        // Write-allocate, then evict and write back word 2.
        access(1'b1, 32'h408, 32'hCAFE_F00D, 2, 2);
        access(1'b0, 32'h608, 32'h0, 2, 3);
        check("wb_word2_in_mem", mem[32'h400][95:64], 32'hCAFE_F00D);

        // Spurious ack in IDLE: nothing changes, 0x300 still hits.
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        access(1'b0, 32'h300, 32'h0, 1, 1);

        // Reset in the third ALLOCATE cycle of a cold miss.
        do_reset();
        bus.cpu_req_i  = 1'b1;
        bus.cpu_we_i   = 1'b0;
        bus.cpu_addr_i = 32'h100;
        @(negedge clk);
        check("rm_stall_c0", bus.cpu_stall_o, 1'b1);
        @(posedge clk); #1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("rm_al_req", bus.mem_req_o, 1'b1);
            if (c == 3) rst = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b0;
        model_reset();
        idle_cycle(1'b1);
        idle_cycle(1'b0);
        access(1'b0, 32'h100, 32'h0, 1, 2);

        // Randomized traffic over a few tags per index to mix hits and conflicts.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle_cycle(1'($urandom_range(0, 1)));
            end else begin
                addr = {23'($urandom_range(0, 3)), 4'($urandom), 3'($urandom), 2'b00};
                access(1'($urandom_range(0, 1)), addr, $urandom,
                       $urandom_range(1, 4), $urandom_range(1, 4));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
